// File: rtl/uart_rx_core_if.sv
// Consumer-side bus of the UART receive core: received byte, status flags
// and the read/clear strobes coming back from the UART register block.
interface uart_rx_core_if;
   logic [7:0] rx_data;
   logic       rx_full;
   logic       frame_err;
   logic       overrun;
   logic       rd_ack;
   logic       clr_err;

   // Receive core drives data/status and observes the strobes
   modport master (
      output rx_data,
      output rx_full,
      output frame_err,
      output overrun,
      input  rd_ack,
      input  clr_err
   );

   // Register block observes data/status and drives the strobes
   modport slave (
      input  rx_data,
      input  rx_full,
      input  frame_err,
      input  overrun,
      output rd_ack,
      output clr_err
   );
endinterface

// File: rtl/uart_rx_core.sv
// 16x-oversampled 8N1 UART receiver with a one-deep output register,
// sticky frame-error / overrun flags and a mid-bit majority vote.
module uart_rx_core #(
   parameter int unsigned OSR  = 16,
   parameter int unsigned DIVW = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rx_en,
   input  logic [DIVW-1:0] div_val,
   input  logic            rx,
   uart_rx_core_if.master  bus
);

   localparam int unsigned OSW     = 4;
   localparam int unsigned BITW    = 3;
   localparam logic [OSW-1:0] OS_S0   = OSW'(7);
   localparam logic [OSW-1:0] OS_S1   = OSW'(8);
   localparam logic [OSW-1:0] OS_VOTE = OSW'(9);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OSR - 1);
   localparam logic [BITW-1:0] BIT_LAST = BITW'(7);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t            state;
   state_t            state_d;
   logic              rx_m;
   logic              rx_s;
   logic [DIVW-1:0]   tick_cnt;
   logic              tick;
   logic [OSW-1:0]    os_cnt;
   logic [BITW-1:0]   bit_idx;
   logic              smp7;
   logic              smp8;
   logic [7:0]        sr;

   logic              vote_c;
   logic              vote_tick_c;
   logic              end_tick_c;
   logic              shift_c;
   logic              load_c;
   logic              ferr_c;
   logic              load_ok_c;
   logic              ovr_set_c;

   // Two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   assign tick        = rx_en && (tick_cnt == div_val);
   assign vote_tick_c = tick && (os_cnt == OS_VOTE);
   assign end_tick_c  = tick && (os_cnt == OS_LAST);
   assign vote_c      = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);

   // Frame FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Frame FSM next state and per-clk control strobes
   always_comb begin
      state_d = state;
      shift_c = 1'b0;
      load_c  = 1'b0;
      ferr_c  = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick && !rx_s) state_d = START;
         end
         START: begin
            if (vote_tick_c && vote_c) state_d = IDLE;
            else if (end_tick_c)       state_d = DATA;
         end
         DATA: begin
            shift_c = vote_tick_c;
            if (end_tick_c && (bit_idx == BIT_LAST)) state_d = STOP;
         end
         STOP: begin
            if (vote_tick_c) begin
               if (vote_c) begin
                  load_c  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_c  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            if (tick && rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Disabling the receiver abandons any frame in progress
      if (!rx_en) begin
         state_d = IDLE;
         shift_c = 1'b0;
         load_c  = 1'b0;
         ferr_c  = 1'b0;
      end
   end

   assign load_ok_c = load_c && (!bus.rx_full || bus.rd_ack);
   assign ovr_set_c = load_c && bus.rx_full && !bus.rd_ack;

   // Tick divider, oversample/bit counters, mid-bit samples and shift register
   always_ff @(posedge clk) begin
      if (!rst_n || !rx_en) begin
         tick_cnt <= '0;
         os_cnt   <= '0;
         bit_idx  <= '0;
         smp7     <= 1'b0;
         smp8     <= 1'b0;
         sr       <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + DIVW'(1);
         if (state == IDLE)      os_cnt <= '0;
         else if (tick)          os_cnt <= os_cnt + OSW'(1);
         if (state == START)     bit_idx <= '0;
         else if (state == DATA && end_tick_c) bit_idx <= bit_idx + BITW'(1);
         if (tick && os_cnt == OS_S0) smp7 <= rx_s;
         if (tick && os_cnt == OS_S1) smp8 <= rx_s;
         if (shift_c)            sr[bit_idx] <= vote_c;
      end
   end

   // Output register and sticky flags; a flag being set beats a clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rx_data   <= 8'h00;
         bus.rx_full   <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         if (load_ok_c) begin
            bus.rx_data <= sr;
            bus.rx_full <= 1'b1;
         end else if (bus.rd_ack) begin
            bus.rx_full <= 1'b0;
         end
         bus.frame_err <= ferr_c    | (bus.frame_err & ~bus.clr_err);
         bus.overrun   <= ovr_set_c | (bus.overrun   & ~bus.clr_err);
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: clean frames, start glitch, framing
// error/break, overrun with and without a same-clk read, enable abort and reset.
module tb_uart_rx_core;
   localparam int unsigned DIVW = 10;
   localparam int unsigned ST_IDLE  = 0;
   localparam int unsigned ST_BREAK = 4;

   logic            clk;
   logic            rst_n;
   logic            rx_en;
   logic [DIVW-1:0] div_val;
   logic            rx;
   int              n_cmp;
   int              n_err;
   logic            found;

   uart_rx_core_if bus ();

   uart_rx_core #(.OSR(16), .DIVW(DIVW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_en   (rx_en),
      .div_val (div_val),
      .rx      (rx),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      clks(n);
   endtask

   // 8N1 frame at 16 clk per bit; rx is left at the stop-bit level
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      clks(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         clks(16);
      end
      rx = stop;
      clks(16);
   endtask

   task automatic ack();
      bus.rd_ack = 1'b1;
      clks(1);
      bus.rd_ack = 1'b0;
   endtask

   task automatic clear_err();
      bus.clr_err = 1'b1;
      clks(1);
      bus.clr_err = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      found       = 1'b0;
      rst_n       = 1'b0;
      rx_en       = 1'b1;
      div_val     = '0;
      rx          = 1'b1;
      bus.rd_ack  = 1'b0;
      bus.clr_err = 1'b0;
      clks(3);
      chk("rst_data",  32'(bus.rx_data),   32'h00);
      chk("rst_full",  32'(bus.rx_full),   32'h0);
      chk("rst_ferr",  32'(bus.frame_err), 32'h0);
      chk("rst_ovr",   32'(bus.overrun),   32'h0);
      rst_n = 1'b1;
      idle(10);

      // Clean frame
      send_frame(8'hA5, 1'b1);
      chk("a5_data", 32'(bus.rx_data),   32'hA5);
      chk("a5_full", 32'(bus.rx_full),   32'h1);
      chk("a5_ferr", 32'(bus.frame_err), 32'h0);
      chk("a5_ovr",  32'(bus.overrun),   32'h0);
      ack();
      chk("a5_ack_full", 32'(bus.rx_full), 32'h0);
      idle(8);

      // Four-clk low glitch must be rejected by the start-bit vote
      rx = 1'b0;
      clks(4);
      idle(40);
      chk("glitch_state", 32'(dut.state),   32'(ST_IDLE));
      chk("glitch_full",  32'(bus.rx_full), 32'h0);
      chk("glitch_ferr",  32'(bus.frame_err), 32'h0);
      chk("glitch_data",  32'(bus.rx_data), 32'hA5);
      send_frame(8'h5A, 1'b1);
      chk("5a_data", 32'(bus.rx_data), 32'h5A);
      chk("5a_full", 32'(bus.rx_full), 32'h1);
      ack();
      idle(8);

      // Stop bit low: framing error, then BREAK until the line is high
      send_frame(8'h3C, 1'b0);
      clks(20);
      chk("3c_ferr",  32'(bus.frame_err), 32'h1);
      chk("3c_full",  32'(bus.rx_full),   32'h0);
      chk("3c_break", 32'(dut.state),     32'(ST_BREAK));
      chk("3c_data",  32'(bus.rx_data),   32'h5A);
      idle(8);
      chk("3c_idle",  32'(dut.state),     32'(ST_IDLE));
      send_frame(8'h01, 1'b1);
      chk("01_data", 32'(bus.rx_data),   32'h01);
      chk("01_ferr", 32'(bus.frame_err), 32'h1);
      clear_err();
      chk("clr_ferr", 32'(bus.frame_err), 32'h0);
      ack();
      idle(8);

      // Overrun: second byte while the first is still unread
      send_frame(8'h11, 1'b1);
      idle(8);
      send_frame(8'h22, 1'b1);
      chk("ovr_data", 32'(bus.rx_data), 32'h11);
      chk("ovr_flag", 32'(bus.overrun), 32'h1);
      chk("ovr_full", 32'(bus.rx_full), 32'h1);
      clear_err();
      chk("ovr_clr",  32'(bus.overrun), 32'h0);
      ack();
      idle(8);

      // Same again, but with the read landing in the exact load clk
      send_frame(8'h11, 1'b1);
      idle(8);
      found = 1'b0;
      fork
         send_frame(8'h22, 1'b1);
         begin
            for (int i = 0; i < 300 && !found; i++) begin
               @(negedge clk);
               if (dut.load_c) begin
                  found      = 1'b1;
                  bus.rd_ack = 1'b1;
                  @(negedge clk);
                  bus.rd_ack = 1'b0;
               end
            end
         end
      join
      chk("ack_load_seen", 32'(found),           32'h1);
      chk("ack_load_data", 32'(bus.rx_data),     32'h22);
      chk("ack_load_full", 32'(bus.rx_full),     32'h1);
      chk("ack_load_ovr",  32'(bus.overrun),     32'h0);
      ack();
      idle(8);

      // Receiver disabled after three data bits of 0xFF
      rx = 1'b0;
      clks(16);
      rx = 1'b1;
      clks(48);
      rx_en = 1'b0;
      clks(1);
      chk("dis_state", 32'(dut.state), 32'(ST_IDLE));
      clks(150);
      chk("dis_full",  32'(bus.rx_full), 32'h0);
      chk("dis_data",  32'(bus.rx_data), 32'h22);
      chk("dis_ovr",   32'(bus.overrun), 32'h0);
      rx_en = 1'b1;
      idle(8);
      send_frame(8'h80, 1'b1);
      chk("80_data", 32'(bus.rx_data), 32'h80);
      chk("80_full", 32'(bus.rx_full), 32'h1);
      idle(8);

      // Reset mid-frame with a full register and overrun set
      send_frame(8'h44, 1'b1);
      chk("pre_rst_ovr",  32'(bus.overrun), 32'h1);
      idle(8);
      rx = 1'b0;
      clks(16);
      rx = 1'b1;
      clks(40);
      rst_n = 1'b0;
      clks(1);
      chk("mid_rst_data",  32'(bus.rx_data),   32'h00);
      chk("mid_rst_full",  32'(bus.rx_full),   32'h0);
      chk("mid_rst_ovr",   32'(bus.overrun),   32'h0);
      chk("mid_rst_ferr",  32'(bus.frame_err), 32'h0);
      chk("mid_rst_state", 32'(dut.state),     32'(ST_IDLE));
      rst_n = 1'b1;
      idle(20);
      send_frame(8'hC3, 1'b1);
      chk("c3_data", 32'(bus.rx_data),   32'hC3);
      chk("c3_full", 32'(bus.rx_full),   32'h1);
      chk("c3_ferr", 32'(bus.frame_err), 32'h0);
      chk("c3_ovr",  32'(bus.overrun),   32'h0);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
